// File: rtl/fredkin_mux_pipe.sv
// Pipelined N_IN:1 multiplexer tree built from Fredkin (controlled-swap) gates, one register
// stage per tree level, with per-bit conservation checking and a sticky error flag.
module fredkin_mux_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_IN  = 4,
  localparam int unsigned SW   = $clog2(N_IN)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SW-1:0]             sel,
  input  logic [N_IN*WIDTH-1:0]     data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          mux_out,
  output logic [(N_IN-1)*WIDTH-1:0] garbage_out,
  input  logic                      inj_fault,
  output logic                      err,
  input  logic                      err_clr
);

  logic          en;
  logic [SW-1:0] mm_lvl;

  // One global stall: every stage shifts together or holds together
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar L = 0; L < SW; L++) begin : g_lvl
    localparam int unsigned NI = N_IN >> L;
    localparam int unsigned NG = NI / 2;
    localparam int unsigned GA = N_IN - NG;

    logic [NI*WIDTH-1:0] a_in;
    logic [SW-L-1:0]     s_in;
    logic                v_in;
    logic                inj;
    logic                mm;
    logic [NG*WIDTH-1:0] q_c;
    logic [NG*WIDTH-1:0] r_c;
    logic [NG*WIDTH-1:0] q_reg;
    logic [GA*WIDTH-1:0] g_nxt;
    logic [GA*WIDTH-1:0] g_reg;
    logic                v_reg;

    // Level 0 reads the request ports; higher levels read the previous stage
    if (L == 0) begin : g_src
      assign a_in  = data;
      assign s_in  = sel;
      assign v_in  = in_valid;
      assign inj   = inj_fault;
      assign g_nxt = r_c;
    end else begin : g_src
      assign a_in  = g_lvl[L-1].q_reg;
      assign s_in  = g_lvl[L-1].g_fwd.s_reg;
      assign v_in  = g_lvl[L-1].v_reg;
      assign inj   = 1'b0;
      assign g_nxt = {r_c, g_lvl[L-1].g_reg};
    end

    // Fredkin gate bits: Q selects, R keeps the rejected input, P=C is dropped
    always_comb begin
      logic av;
      logic bv;
      logic qv;
      logic rv;
      q_c = '0;
      r_c = '0;
      mm  = 1'b0;
      av  = 1'b0;
      bv  = 1'b0;
      qv  = 1'b0;
      rv  = 1'b0;
      for (int j = 0; j < int'(NG); j++) begin
        for (int b = 0; b < int'(WIDTH); b++) begin
          av = a_in[(2*j)*int'(WIDTH) + b];
          bv = a_in[(2*j+1)*int'(WIDTH) + b];
          qv = (~s_in[0] & av) | (s_in[0] & bv);
          rv = (~s_in[0] & bv) | (s_in[0] & av);
          if (j == 0 && b == 0) qv = qv ^ inj;
          q_c[j*int'(WIDTH) + b] = qv;
          r_c[j*int'(WIDTH) + b] = rv;
          if ((2'(s_in[0]) + 2'(av) + 2'(bv)) != (2'(s_in[0]) + 2'(qv) + 2'(rv))) mm = 1'b1;
        end
      end
    end

    assign mm_lvl[L] = en & v_in & mm;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_reg <= 1'b0;
        q_reg <= '0;
        g_reg <= '0;
      end else if (en) begin
        v_reg <= v_in;
        if (v_in) begin
          q_reg <= q_c;
          g_reg <= g_nxt;
        end
      end
    end

    // Select bits still needed by later levels ride along with the request
    if (L < SW - 1) begin : g_fwd
      logic [SW-L-2:0] s_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s_reg <= '0;
        else if (en && v_in) s_reg <= s_in[SW-L-1:1];
      end
    end
  end

  assign out_valid   = g_lvl[SW-1].v_reg;
  assign mux_out     = g_lvl[SW-1].q_reg;
  assign garbage_out = g_lvl[SW-1].g_reg;

  // Sticky error; a new violation outranks a clear in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          err <= 1'b0;
    else if (|mm_lvl)    err <= 1'b1;
    else if (err_clr)    err <= 1'b0;
  end

endmodule
